// File: rtl/nfa_pkg.sv
// Shared definitions for the NFA chain engine: element mode encodings,
// match counter width and a width helper that never returns zero.
package nfa_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_STAR   = 2'b01,
    MODE_PLUS   = 2'b10
  } nfa_mode_e;

  localparam int MATCH_CNT_W = 8;

  // ceil(log2(v)), floored at 1 so single-entry tables still get a port bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'(1) << r) < 64'(v)) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nfa_chain_engine_if.sv
// Byte stream, element config and match result bundle for the NFA engine.
// With NFA_ANCHOR_EN defined the bundle also carries cfg_anchor.
interface nfa_chain_engine_if #(
  parameter int N_ELEM  = 16,
  parameter int N_CLASS = 64,
  parameter int POS_W   = 16
);
  import nfa_pkg::*;
  localparam int AW = clog2(N_ELEM);
  localparam int CW = clog2(N_CLASS);

  logic               en;
  logic               sod;
  logic [N_CLASS-1:0] cls_in;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [CW-1:0]      cfg_class;
  logic [1:0]         cfg_mode;
  logic [AW:0]        cfg_len;
`ifdef NFA_ANCHOR_EN
  logic               cfg_anchor;
`endif
  logic                   match;
  logic                   match_pulse;
  logic [POS_W-1:0]       match_pos;
  logic [MATCH_CNT_W-1:0] match_cnt;

  modport master (
    output en, sod, cls_in, cfg_we, cfg_addr, cfg_class, cfg_mode, cfg_len,
`ifdef NFA_ANCHOR_EN
    output cfg_anchor,
`endif
    input  match, match_pulse, match_pos, match_cnt
  );

  modport slave (
    input  en, sod, cls_in, cfg_we, cfg_addr, cfg_class, cfg_mode, cfg_len,
`ifdef NFA_ANCHOR_EN
    input  cfg_anchor,
`endif
    output match, match_pulse, match_pos, match_cnt
  );
endinterface

// File: rtl/nfa_elem.sv
// One pattern element: class/mode config, its state bit, and two chain
// links -- e (enable from current state) and h (enable from next state,
// used to detect a completed match on the byte being consumed).
module nfa_elem
  import nfa_pkg::*;
#(
  parameter int N_CLASS = 64,
  parameter int CW      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic               clr_s,
  input  logic               adv,
  input  logic               sod_clr,
  input  logic [CW-1:0]      wr_class,
  input  logic [1:0]         wr_mode,
  input  logic [N_CLASS-1:0] cls_in,
  input  logic               e_in,
  input  logic               h_in,
  output logic               e_out,
  output logic               h_out
);
  logic [CW-1:0] cls_q;
  logic [1:0]    mode_q;
  logic          s_q;
  logic          star, rep, s_cur, s_nxt;

  // reserved mode 11 falls through to single behaviour
  assign star  = (mode_q == MODE_STAR);
  assign rep   = star | (mode_q == MODE_PLUS);
  // start-of-data wipes state before the byte is evaluated
  assign s_cur = s_q & ~sod_clr;
  assign s_nxt = cls_in[cls_q] & (e_in | (rep & s_cur));
  assign e_out = s_cur | (star & e_in);
  assign h_out = s_nxt | (star & h_in);

  // element config register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cls_q  <= '0;
      mode_q <= MODE_SINGLE;
    end else if (wr) begin
      cls_q  <= wr_class;
      mode_q <= wr_mode;
    end

  // state bit: any config write restarts the pattern
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     s_q <= 1'b0;
    else if (clr_s) s_q <= 1'b0;
    else if (adv)   s_q <= s_nxt;
endmodule

// File: rtl/nfa_chain_engine.sv
// Unanchored NFA pattern chain over a decoded char-class stream.
// Optional NFA_ANCHOR_EN adds cfg_anchor, pinning the pattern to byte 0.
module nfa_chain_engine
  import nfa_pkg::*;
#(
  parameter int N_ELEM  = 16,
  parameter int N_CLASS = 64,
  parameter int POS_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  nfa_chain_engine_if.slave bus
);
  localparam int AW = clog2(N_ELEM);
  localparam int CW = clog2(N_CLASS);
  localparam logic [MATCH_CNT_W-1:0] CNT_MAX = '1;

  logic [N_ELEM:0]        e_ch, h_ch;
  logic [N_ELEM-1:0]      wr_vec;
  logic [N_CLASS-1:0]     cls_in;
  logic [CW-1:0]          cfg_class;
  logic [1:0]             cfg_mode;
  logic                   e0, hit, sod_clr, unused_tail;
  logic [POS_W-1:0]       off_q, pos_q, eff_off;
  logic [MATCH_CNT_W-1:0] cnt_q, base_cnt;
  logic                   match_q, pulse_q, base_match;

  assign sod_clr   = bus.en & bus.sod;
  assign cls_in    = bus.cls_in;
  assign cfg_class = bus.cfg_class;
  assign cfg_mode  = bus.cfg_mode;

`ifdef NFA_ANCHOR_EN
  logic at_start;
  // offset 0 after reset, until the first byte is consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      at_start <= 1'b1;
    else if (bus.en) at_start <= 1'b0;
  assign e0 = ~bus.cfg_anchor | sod_clr | at_start;
`else
  assign e0 = 1'b1;
`endif

  assign e_ch[0]     = e0;
  assign h_ch[0]     = e0;
  assign unused_tail = e_ch[N_ELEM];

  // one-hot config write select
  always_comb begin
    wr_vec = '0;
    if (bus.cfg_we && int'(bus.cfg_addr) < N_ELEM) wr_vec[bus.cfg_addr] = 1'b1;
  end

  nfa_elem #(.N_CLASS(N_CLASS), .CW(CW)) u_elem [N_ELEM-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr_vec),
    .clr_s    (bus.cfg_we),
    .adv      (bus.en),
    .sod_clr  (sod_clr),
    .wr_class (cfg_class),
    .wr_mode  (cfg_mode),
    .cls_in   (cls_in),
    .e_in     (e_ch[N_ELEM-1:0]),
    .h_in     (h_ch[N_ELEM-1:0]),
    .e_out    (e_ch[N_ELEM:1]),
    .h_out    (h_ch[N_ELEM:1])
  );

  // hit = enable past the last active element, on next-state values;
  // a byte consumed alongside a config write never counts
  always_comb begin
    hit = 1'b0;
    if (bus.en && !bus.cfg_we && bus.cfg_len != '0 && int'(bus.cfg_len) <= N_ELEM)
      hit = h_ch[bus.cfg_len];
  end

  assign eff_off    = bus.sod ? '0 : off_q;
  assign base_match = match_q & ~bus.sod;
  assign base_cnt   = bus.sod ? '0 : cnt_q;

  // offset counter and match reporting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      off_q   <= '0;
      match_q <= 1'b0;
      pulse_q <= 1'b0;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= hit;
      if (bus.en) begin
        off_q <= eff_off + POS_W'(1);
        if (bus.sod) begin
          match_q <= 1'b0;
          pos_q   <= '0;
          cnt_q   <= '0;
        end
        if (hit) begin
          match_q <= 1'b1;
          if (!base_match)         pos_q <= eff_off;
          if (base_cnt != CNT_MAX) cnt_q <= base_cnt + 1'b1;
        end
      end
    end

  assign bus.match       = match_q;
  assign bus.match_pulse = pulse_q;
  assign bus.match_pos   = pos_q;
  assign bus.match_cnt   = cnt_q;
endmodule

// File: doc/nfa_chain_engine.md
NFA_CHAIN_ENGINE -- requirements
Module: nfa_chain_engine

Interface
REQ-001 SHALL have parameter N_ELEM, default 16, meaning max pattern elements (1..64).
REQ-002 SHALL have parameter N_CLASS, default 64, meaning width of char-class vector.
REQ-003 SHALL have parameter POS_W, default 16, meaning byte-offset counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  byte valid; one payload byte per cycle when high.
REQ-007 sod  in  1  start of data; qualifies the byte presented with en as byte 0 of a new stream.
REQ-008 cls_in  in  N_CLASS  decoded char-class hits for current byte.
REQ-009 cfg_we  in  1  element config write strobe.
REQ-010 cfg_addr  in  clog2(N_ELEM)  element index.
REQ-011 cfg_class  in  clog2(N_CLASS)  class index for element.
REQ-012 cfg_mode  in  2  00 single, 01 star (0+), 10 plus (1+), 11 reserved=single.
REQ-013 cfg_len  in  clog2(N_ELEM)+1  active element count; sampled every cycle.
REQ-014 match  out  1  sticky match flag for current stream.
REQ-015 match_pulse  out  1  one-cycle strobe per completing byte.
REQ-016 match_pos  out  POS_W  offset of first completing byte.
REQ-017 match_cnt  out  8  completing-byte count, saturating.

Function
REQ-018 Element i SHALL hold config (class c_i, mode m_i) and state bit s_i.
REQ-019 Enable chain: e_0 = 1 (unanchored); e_(i+1) = s_i OR (m_i==star AND e_i), combinational within one cycle.
REQ-020 On en: s_i <= cls_in[c_i] AND (e_i OR (m_i in {star,plus} AND s_i)); without en all state holds.
REQ-021 Hit SHALL be e_len evaluated on next-state values; cfg_len=0 SHALL never hit.
REQ-022 Latency: hit byte at edge t -> match_pulse high for cycle t+1 only; match high from t+1 until sod/reset.
REQ-023 match_pos SHALL capture the byte offset (0 = sod byte) of first hit only; later hits leave it unchanged.
REQ-024 match_cnt SHALL increment per hit byte, saturate at 255.
REQ-025 Byte offset counter SHALL wrap modulo 2^POS_W; match_pos reports wrapped value.
REQ-026 sod with en: state, match, match_pos, match_cnt, offset cleared before byte evaluated; byte itself processed as offset 0 and may hit.
REQ-027 sod without en SHALL be ignored.
REQ-028 cfg_we: element written at edge; all s_i cleared same edge; match/cnt/pos retained; byte with en that cycle evaluated with old config, result discarded.
REQ-029 Trailing star elements SHALL be transparent: pattern matches once last non-star element matches.

Reset
REQ-030 rst_n low SHALL asynchronously clear s_i, match, match_pulse, match_pos, match_cnt, offset counter.
REQ-031 Reset SHALL clear element config to class 0, mode single; cfg_len is external.
REQ-032 Reset deassertion mid-stream SHALL resume at offset 0 with empty state; no hit on first cycle absent en.

Configuration
REQ-033 Macro NFA_ANCHOR_EN SHALL add input cfg_anchor (1 bit).
REQ-034 With NFA_ANCHOR_EN and cfg_anchor=1: e_0 = 1 only for the byte at offset 0 after sod, else 0.
REQ-035 Without NFA_ANCHOR_EN: no cfg_anchor port, e_0 = 1 always.

Structure
REQ-036 Package nfa_pkg SHALL hold mode encodings (MODE_SINGLE/STAR/PLUS), MATCH_CNT_W=8, clog2 helper.
REQ-037 Sub-module nfa_elem SHALL implement one element (config regs, s_i, e_(i+1) output); top generates N_ELEM instances.

Verification
REQ-038 Program ".definition\s*(" (13 elements, element 11 star on class \s); stream "x.definition  (" -> match_pulse cycle after "(", match_pos=14, match_cnt=1.
REQ-039 Same config, ".definition(" -> hit at offset 11 (star zero repeats).
REQ-040 "a+b" plus mode, stream "aaab ab" -> match_cnt=2, match_pos=3.
REQ-041 Hit then sod+en on next byte -> match, match_cnt, match_pos cleared; no stale pulse.
REQ-042 cfg_we mid-pattern ".defin" then rest "ition(" -> no hit; rst_n pulse mid-stream -> all outputs 0 asynchronously.
REQ-043 With NFA_ANCHOR_EN, cfg_anchor=1, "x.definition(" -> no hit; ".definition(" -> hit at offset 11.
